alu_op_sequencer: RTL and testbench

Upstream issue stage for the TotalALU datapath. It accepts one R-type operation at a time (funct, dataA, dataB) over a valid/ready handshake and decodes the funct. It then drives dataA/dataB/Signal into the ALU, holds them for the ALU latency or for the full DIVU duration, and captures Output into a single-entry result register with a valid/ready handshake. It serialises DIVU against later MFHI/MFLO so HI/LO are always settled before being read.

---
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue stage for the TotalALU: one R-type op at a time, held for the ALU/divider latency.
// Optional macro DIV0_TRAP_EN turns a DIVU with in_b==0 into an error beat instead of an issue.
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ALU_LAT    = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_dataA,
  output logic [DATA_W-1:0] alu_dataB,
  output logic [5:0]        alu_signal,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [5:0]        out_funct,
  output logic              out_err
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 2);

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DIV_WAIT
  } state_e;

  typedef enum logic [1:0] {
    CLS_SINGLE,
    CLS_DIV,
    CLS_ILLEGAL
  } op_class_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dataA_q;
  logic [DATA_W-1:0]   dataB_q;
  logic [5:0]          signal_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_result_q;
  logic [5:0]          out_funct_q;
  logic                out_err_q;
  op_class_e           op_class_d;

  always_comb begin
    op_class_d = CLS_ILLEGAL;
    case (in_funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO:
        op_class_d = CLS_SINGLE;
      F_DIVU: begin
`ifdef DIV0_TRAP_EN
        op_class_d = (in_b == '0) ? CLS_ILLEGAL : CLS_DIV;
`else
        op_class_d = CLS_DIV;
`endif
      end
      default: op_class_d = CLS_ILLEGAL;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) && !out_valid_q;

  // The funct being executed lives on signal_q, so it doubles as the pending out_funct.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dataA_q      <= '0;
      dataB_q      <= '0;
      signal_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_funct_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (in_valid && !out_valid_q) begin
            case (op_class_d)
              CLS_SINGLE: begin
                dataA_q  <= in_a;
                dataB_q  <= in_b;
                signal_q <= in_funct;
                cnt_q    <= CNT_W'(ALU_LAT);
                state_q  <= ST_ISSUE;
              end
              CLS_DIV: begin
                dataA_q  <= in_a;
                dataB_q  <= in_b;
                signal_q <= in_funct;
                cnt_q    <= CNT_W'(DIV_CYCLES);
                state_q  <= ST_DIV_WAIT;
              end
              default: begin
                out_result_q <= '0;
                out_funct_q  <= in_funct;
                out_err_q    <= 1'b1;
                out_valid_q  <= 1'b1;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (cnt_q == '0) begin
            out_result_q <= alu_result;
            out_funct_q  <= signal_q;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            signal_q     <= '0;
            state_q      <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          if (cnt_q == '0) begin
            signal_q <= '0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_dataA  = dataA_q;
  assign alu_dataB  = dataB_q;
  assign alu_signal = signal_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_funct  = out_funct_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural TotalALU attached.
module tb_alu_op_sequencer;

  localparam int DATA_W     = 32;
  localparam int ALU_LAT    = 1;
  localparam int DIV_CYCLES = 32;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_funct;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] alu_dataA;
  logic [DATA_W-1:0] alu_dataB;
  logic [5:0]        alu_signal;
  logic [DATA_W-1:0] alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [5:0]        out_funct;
  logic              out_err;

  int passed = 0;
  int total  = 0;

  alu_op_sequencer #(
    .DATA_W    (DATA_W),
    .ALU_LAT   (ALU_LAT),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct  (in_funct),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_dataA (alu_dataA),
    .alu_dataB (alu_dataB),
    .alu_signal(alu_signal),
    .alu_result(alu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_funct (out_funct),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // TotalALU stand-in: registered Output (one edge of latency), HI/LO written when the divide completes.
  logic [DATA_W-1:0] hi_r, lo_r;
  int                div_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      div_cnt    <= 0;
    end else begin
      case (alu_signal)
        F_AND:   alu_result <= alu_dataA & alu_dataB;
        F_OR:    alu_result <= alu_dataA | alu_dataB;
        F_ADD:   alu_result <= alu_dataA + alu_dataB;
        F_SUB:   alu_result <= alu_dataA - alu_dataB;
        F_SLT:   alu_result <= ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
        F_SRL:   alu_result <= alu_dataA >> alu_dataB[4:0];
        F_MFHI:  alu_result <= hi_r;
        F_MFLO:  alu_result <= lo_r;
        default: alu_result <= '0;
      endcase
      if (alu_signal == F_DIVU) begin
        div_cnt <= div_cnt + 1;
        if (div_cnt == DIV_CYCLES - 1 && alu_dataB != '0) begin
          lo_r <= alu_dataA / alu_dataB;
          hi_r <= alu_dataA % alu_dataB;
        end
      end else begin
        div_cnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk({name, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Handshake one op, then count edges until out_valid (0 = visible right after the handshake edge).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [5:0] sig_hs);
    wait_ready("run_op");
    in_valid = 1'b1;
    in_funct = f;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sig_hs   = alu_signal;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          lat;
    int          cnt;
    logic [5:0]  sig_hs;
    logic        ok;

    vecs[0]  = '{F_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 2};
    vecs[1]  = '{F_AND, 32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b0, 2};
    vecs[2]  = '{F_OR,  32'h0000F0F0,   32'h00000F0F,   32'h0000FFFF,   1'b0, 2};
    vecs[3]  = '{F_SUB, 32'd9,          32'd4,          32'd5,          1'b0, 2};
    vecs[4]  = '{F_SUB, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 2};
    vecs[5]  = '{F_SLT, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 2};
    vecs[6]  = '{F_SLT, 32'd5,          32'd3,          32'd0,          1'b0, 2};
    vecs[7]  = '{F_SRL, 32'h80000000,   32'd4,          32'h08000000,   1'b0, 2};
    vecs[8]  = '{F_ADD, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 2};
    vecs[9]  = '{6'b000111, 32'd3,      32'd4,          32'd0,          1'b1, 0};
    vecs[10] = '{6'b111111, 32'd8,      32'd9,          32'd0,          1'b1, 0};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_funct  = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_alu_signal", {26'd0, alu_signal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_err",    {31'd0, out_err}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_funct",  {26'd0, out_funct}, 32'd0);
    chk("rst_alu_signal", {26'd0, alu_signal}, 32'd0);
    chk("rst_alu_dataA",  alu_dataA, 32'd0);
    chk("rst_alu_dataB",  alu_dataB, 32'd0);
    chk("rst_in_ready",   {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, sig_hs);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_funct", i), {26'd0, out_funct}, {26'd0, vecs[i].f});
      chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_sig_at_hs", i), {26'd0, sig_hs}, vecs[i].err ? 32'd0 : {26'd0, vecs[i].f});
      chk($sformatf("v%0d_sig_idle", i), {26'd0, alu_signal}, 32'd0);
      if (!vecs[i].err) chk($sformatf("v%0d_dataA", i), alu_dataA, vecs[i].a);
      consume();
      chk($sformatf("v%0d_cleared", i), {31'd0, out_valid}, 32'd0);
    end

    // DIVU 100/7 then MFLO, MFHI: in_ready low for DIV_CYCLES+1 cycles, no output beat.
    wait_ready("divu");
    in_valid = 1'b1; in_funct = F_DIVU; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("divu_sig", {26'd0, alu_signal}, {26'd0, F_DIVU});
    chk("divu_dataB", alu_dataB, 32'd7);
    cnt = 0;
    ok  = 1'b1;
    while (!in_ready && cnt < 100) begin
      if (out_valid || alu_signal != F_DIVU) ok = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    chk("divu_busy_cycles", cnt, DIV_CYCLES + 1);
    chk("divu_no_beat_sig_held", {31'd0, ok}, 32'd1);
    chk("divu_sig_after", {26'd0, alu_signal}, 32'd0);
    run_op(F_MFLO, 32'd0, 32'd0, lat, sig_hs);
    chk("mflo_result", out_result, 32'd14);
    chk("mflo_latency", lat, 2);
    consume();
    run_op(F_MFHI, 32'd0, 32'd0, lat, sig_hs);
    chk("mfhi_result", out_result, 32'd2);
    consume();

    // Backpressure: result must stay put while out_ready is low.
    run_op(F_SUB, 32'd9, 32'd4, lat, sig_hs);
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (out_result != 32'd5 || !out_valid || in_ready) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("bp_stable", {31'd0, ok}, 32'd1);
    chk("bp_result", out_result, 32'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_valid_clear", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef DIV0_TRAP_EN
    run_op(F_DIVU, 32'd10, 32'd0, lat, sig_hs);
    chk("div0_latency", lat, 0);
    chk("div0_err", {31'd0, out_err}, 32'd1);
    chk("div0_funct", {26'd0, out_funct}, {26'd0, F_DIVU});
    chk("div0_result", out_result, 32'd0);
    chk("div0_sig", {26'd0, sig_hs}, 32'd0);
    consume();
`else
    wait_ready("div0");
    in_valid = 1'b1; in_funct = F_DIVU; in_a = 32'd10; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("div0_issued_sig", {26'd0, alu_signal}, {26'd0, F_DIVU});
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("div0_busy_cycles", cnt, DIV_CYCLES + 1);
    chk("div0_no_beat", {31'd0, out_valid}, 32'd0);
`endif

    // Reset in the middle of DIV_WAIT abandons the divide.
    wait_ready("rst_div");
    in_valid = 1'b1; in_funct = F_DIVU; in_a = 32'd50; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("middiv_busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("middiv_sig", {26'd0, alu_signal}, 32'd0);
    chk("middiv_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("middiv_in_ready", {31'd0, in_ready}, 32'd1);
    run_op(F_ADD, 32'd1, 32'd1, lat, sig_hs);
    chk("middiv_add_result", out_result, 32'd2);
    chk("middiv_add_latency", lat, 2);
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
